multi_pulse_gen: RTL
====================

# multi_pulse_gen

Parametrised N-channel pulse-train generator; successor to the single-shot delay/width pulse PIO path. Each channel latches delay, width, period and repeat count on a start edge from an HPS PIO, then emits a programmed burst, a continuous train, or a single pulse on its output. It sits in the FPGA fabric between the lightweight-bridge PIO exports and the board pins, clocked by the 100 MHz fabric PLL clock.

## Interface
Parameters:
- N_CH, 4, number of independent channels
- CNT_W, 32, width of delay/width/period fields (cycles)
- REP_W, 16, width of repeat-count field

Ports (channel i occupies slice [i*W +: W] of each flattened bus):
- clk  in  1  fabric clock, sole clock domain
- reset  in  1  synchronous, active-high; one clock, no other domains
- start  in  N_CH  level from PIO; rising edge (sampled low then high) arms the channel
- abort  in  N_CH  level; while high, the channel is forced idle
- cfg_delay  in  N_CH*CNT_W  cycles from start edge to first rising edge
- cfg_width  in  N_CH*CNT_W  high time per pulse, cycles
- cfg_period  in  N_CH*CNT_W  rise-to-rise spacing, cycles
- cfg_repeat  in  N_CH*REP_W  number of pulses; 0 = continuous
- pulse_out  out  N_CH  registered pulse outputs
- busy  out  N_CH  channel armed or emitting
- done  out  N_CH  one-cycle strobe after final pulse of a finite train

## Operation
- Per-channel FSM: IDLE -> DELAY -> HIGH -> LOW -> HIGH ... -> IDLE.
- IDLE: on start edge at cycle t with abort low and cfg_width != 0: latch all four cfg fields, load delay counter, go DELAY. cfg fields ignored at all other times.
- cfg_width == 0: start edge ignored; busy stays low, no done.
- DELAY: counts latched delay; D == 0 is legal.
- HIGH: pulse_out high exactly W cycles; then LOW, or IDLE if final pulse.
- LOW: lasts Pe - W cycles, Pe = max(P, W+1), computed at CNT_W+1 bits (no wrap when W is all ones).
- Repeat: pulses remaining decremented at each rising edge; R == 0 never decrements, runs until abort/reset.
- Start edges while busy: ignored, not queued; edge detector still tracks level so a held-high start does not re-arm on return to IDLE.
- abort high: next cycle pulse_out=0, busy=0, state IDLE, no done. Abort same cycle as start edge: abort wins.
- Channels fully independent; no shared counters.

## Timing
- Reset: pulse_out=0, busy=0, done=0, all FSMs IDLE, edge-detector history=0 (start held high through reset does not fire).
- Start edge at t: busy high from t+1; first pulse_out rise at t+1+D.
- Pulse k (k from 0) high during cycles [t+1+D+k*Pe, t+D+k*Pe+W].
- Finite train: busy falls and done pulses for exactly one cycle on the first cycle pulse_out is low after final pulse; next start edge may be accepted that same cycle.
- Reset mid-operation: outputs return to reset values next cycle, no done.

## Structure
- Package multi_pulse_gen_pkg: state enum (IDLE, DELAY, HIGH, LOW), channel cfg struct typedef parametrised by widths, local constants for field slicing.
- Sub-module pulse_chan: one channel (edge detect, FSM, delay/phase counter, repeat counter); top instantiates N_CH copies via generate and slices buses.

## Test plan
- Ch0 D=3, W=2, R=1, start edge at cycle 10 -> pulse_out high cycles 14-15, busy 11-15, done at 16 only.
- Ch1 D=0, W=1, P=4, R=3, edge at 0 -> highs at 1, 5, 9; done at 10; busy falls at 10.
- Ch2 D=0, W=5, P=3, R=2 (P<W+1), edge at 0 -> highs 1-5 and 7-11, done at 12.
- Ch3 R=0, W=2, P=4, abort raised at cycle 20 -> train runs until 20, pulse_out and busy 0 at 21, no done; abort+start same cycle -> no arm.
- Start re-pulsed while busy and held high past train end -> no retrigger; cfg_width=0 edge -> busy stays 0.
- Reset asserted mid-HIGH on all four channels concurrently running -> all outputs 0 next cycle; later edges re-arm normally.

Source files
------------

// File: rtl/multi_pulse_gen_pkg.sv
// Shared types and default widths for the multi-channel pulse generator.
// The channel state enum is common to every pulse_chan copy.
package multi_pulse_gen_pkg;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_REP_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    HIGH,
    LOW
  } state_t;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] delay;
    logic [DEF_CNT_W-1:0] width;
    logic [DEF_CNT_W-1:0] period;
    logic [DEF_REP_W-1:0] rpt;
  } chan_cfg_t;

endpackage

// File: rtl/multi_pulse_gen_pulse_chan.sv
// One pulse-train channel: start edge detect, FSM,
// phase counter and repeat counter.
module pulse_chan
  import multi_pulse_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [REP_W-1:0] rpt_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o
);

  state_t           state_q;
  logic             low_seen_q;
  logic             pulse_q;
  logic             busy_q;
  logic             done_q;
  logic             cont_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] low_q;
  logic [REP_W-1:0] rep_q;

  logic             edge_d;
  logic [CNT_W-1:0] low_d;
  logic             last_d;

  localparam logic [CNT_W-1:0] C1 = CNT_W'(1);
  localparam logic [REP_W-1:0] R1 = REP_W'(1);

  // Low time is Pe - W with Pe = max(P, W+1); never wraps.
  assign edge_d = start_i & low_seen_q;
  assign low_d  = (period_i > width_i) ?
                  (period_i - width_i) : C1;
  assign last_d = ~cont_q && (rep_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      low_seen_q <= 1'b0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cont_q     <= 1'b0;
      cnt_q      <= '0;
      width_q    <= '0;
      low_q      <= '0;
      rep_q      <= '0;
    end else begin
      low_seen_q <= ~start_i;
      done_q     <= 1'b0;
      if (abort_i) begin
        state_q <= IDLE;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (edge_d && (width_i != '0)) begin
              width_q <= width_i;
              low_q   <= low_d;
              cont_q  <= (rpt_i == '0);
              busy_q  <= 1'b1;
              if (delay_i == '0) begin
                state_q <= HIGH;
                pulse_q <= 1'b1;
                cnt_q   <= width_i - C1;
                rep_q   <= rpt_i - R1;
              end else begin
                state_q <= DELAY;
                cnt_q   <= delay_i - C1;
                rep_q   <= rpt_i;
              end
            end
          end
          DELAY, LOW: begin
            if (cnt_q == '0) begin
              state_q <= HIGH;
              pulse_q <= 1'b1;
              cnt_q   <= width_q - C1;
              if (!cont_q) rep_q <= rep_q - R1;
            end else begin
              cnt_q <= cnt_q - C1;
            end
          end
          HIGH: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - C1;
            end else if (last_d) begin
              state_q <= IDLE;
              pulse_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= LOW;
              pulse_q <= 1'b0;
              cnt_q   <= low_q - C1;
            end
          end
        endcase
      end
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: rtl/multi_pulse_gen.sv
// N-channel pulse-train generator top.
// Slices the flattened cfg buses onto independent channels.
module multi_pulse_gen
  import multi_pulse_gen_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       abort,
  input  logic [N_CH*CNT_W-1:0] cfg_delay,
  input  logic [N_CH*CNT_W-1:0] cfg_width,
  input  logic [N_CH*CNT_W-1:0] cfg_period,
  input  logic [N_CH*REP_W-1:0] cfg_repeat,
  output logic [N_CH-1:0]       pulse_out,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       done
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pulse_chan #(
      .CNT_W(CNT_W),
      .REP_W(REP_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .start_i (start[i]),
      .abort_i (abort[i]),
      .delay_i (cfg_delay[i*CNT_W +: CNT_W]),
      .width_i (cfg_width[i*CNT_W +: CNT_W]),
      .period_i(cfg_period[i*CNT_W +: CNT_W]),
      .rpt_i   (cfg_repeat[i*REP_W +: REP_W]),
      .pulse_o (pulse_out[i]),
      .busy_o  (busy[i]),
      .done_o  (done[i])
    );
  end

endmodule
